// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the single-port SRAM read/write arbiter.
// Address/data widths mirror the AXI4 slave widths used by the beat generators.
package sram_arb_pkg;

    localparam int AXI4_ADDR_WIDTH = 32;
    localparam int AXI4_DATA_WIDTH = 32;
    localparam int RBUF_DEPTH      = 2;
    localparam int RBUF_CNT_W      = $clog2(RBUF_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR    = 2'd1,
        WRESP = 2'd2,
        RD    = 2'd3
    } arb_state_e;

    typedef enum logic {
        GNT_WR = 1'b0,
        GNT_RD = 1'b1
    } grant_e;

    typedef struct packed {
        logic                       last;
        logic [AXI4_DATA_WIDTH-1:0] data;
    } rbuf_entry_t;

endpackage

// File: rtl/sram_rdata_buf.sv
// Two-entry in-order buffer for {last, data} returning from the SRAM.
// Pointers are single bits because the depth is fixed at two.
module sram_rdata_buf
    import sram_arb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  rbuf_entry_t           push_entry,
    input  logic                  pop,
    output rbuf_entry_t           head,
    output logic [RBUF_CNT_W-1:0] count
);

    rbuf_entry_t mem [RBUF_DEPTH];
    logic        wr_ptr;
    logic        rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
            for (int i = 0; i < RBUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/sram_rw_arb.sv
// Burst-granular arbiter giving one single-port SRAM to write or read bursts.
// Build option SRAM_ARB_RR_EN: round-robin tie break; otherwise reads win ties.
//
// state | meaning
// IDLE  | no grant; pick a side when any beat is offered
// WR    | write burst owns the SRAM, one write per beat handshake
// WRESP | write burst done, holding bvalid_o until bready_i
// RD    | read burst owns the SRAM, beats throttled by read credit
module sram_rw_arb
    import sram_arb_pkg::*;
(
    input  logic                         aclk_i,
    input  logic                         aresetn_i,
    input  logic                         wbeat_valid_i,
    output logic                         wbeat_ready_o,
    input  logic [AXI4_ADDR_WIDTH-1:0]   wbeat_addr_i,
    input  logic [AXI4_DATA_WIDTH-1:0]   wbeat_data_i,
    input  logic [AXI4_DATA_WIDTH/8-1:0] wbeat_strb_i,
    input  logic                         wbeat_last_i,
    output logic                         bvalid_o,
    input  logic                         bready_i,
    input  logic                         rbeat_valid_i,
    output logic                         rbeat_ready_o,
    input  logic [AXI4_ADDR_WIDTH-1:0]   rbeat_addr_i,
    input  logic                         rbeat_last_i,
    output logic [AXI4_DATA_WIDTH-1:0]   rdata_o,
    output logic                         rlast_o,
    output logic                         rvalid_o,
    input  logic                         rready_i,
    output logic                         sram_en_o,
    output logic                         sram_we_o,
    output logic [AXI4_ADDR_WIDTH-1:0]   sram_addr_o,
    output logic [AXI4_DATA_WIDTH-1:0]   sram_wdata_o,
    output logic [AXI4_DATA_WIDTH/8-1:0] sram_wstrb_o,
    input  logic [AXI4_DATA_WIDTH-1:0]   sram_rdata_i
);

    arb_state_e            state_q;
    arb_state_e            state_d;
    logic                  gnt_rd;
    logic                  wr_hs;
    logic                  rd_hs;
    logic                  credit;
    logic                  out_pop;
    logic                  rd_inflight_q;
    logic                  rd_last_q;
    logic                  buf_push;
    logic                  buf_pop;
    logic                  buf_empty;
    rbuf_entry_t           buf_head;
    logic [RBUF_CNT_W-1:0] buf_count;

`ifdef SRAM_ARB_RR_EN
    grant_e last_gnt_q;

    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            last_gnt_q <= GNT_WR;
        end else if (state_q == IDLE && (rbeat_valid_i || wbeat_valid_i)) begin
            last_gnt_q <= gnt_rd ? GNT_RD : GNT_WR;
        end
    end

    assign gnt_rd = rbeat_valid_i && (!wbeat_valid_i || last_gnt_q == GNT_WR);
`else
    assign gnt_rd = rbeat_valid_i;
`endif

    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rbeat_valid_i || wbeat_valid_i) state_d = gnt_rd ? RD : WR;
            WR:      if (wr_hs && wbeat_last_i) state_d = WRESP;
            WRESP:   if (bready_i) state_d = IDLE;
            RD:      if (rd_hs && rbeat_last_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign wbeat_ready_o = (state_q == WR);
    assign bvalid_o      = (state_q == WRESP);
    assign wr_hs         = wbeat_valid_i && wbeat_ready_o;

    // Credit counts the read in flight so the buffer can never be oversubscribed.
    assign credit        = ((buf_count + {{(RBUF_CNT_W-1){1'b0}}, rd_inflight_q}) < RBUF_CNT_W'(RBUF_DEPTH))
                           || out_pop;
    assign rbeat_ready_o = (state_q == RD) && credit;
    assign rd_hs         = rbeat_valid_i && rbeat_ready_o;

    assign sram_en_o    = wr_hs || rd_hs;
    assign sram_we_o    = wr_hs;
    assign sram_addr_o  = wr_hs ? wbeat_addr_i : (rd_hs ? rbeat_addr_i : '0);
    assign sram_wdata_o = wr_hs ? wbeat_data_i : '0;
    assign sram_wstrb_o = wr_hs ? wbeat_strb_i : '0;

    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            rd_inflight_q <= 1'b0;
            rd_last_q     <= 1'b0;
        end else begin
            rd_inflight_q <= rd_hs;
            rd_last_q     <= rd_hs && rbeat_last_i;
        end
    end

    // An empty buffer forwards the returning SRAM word directly for N+1 latency.
    assign buf_empty = (buf_count == '0);
    assign rvalid_o  = !buf_empty || rd_inflight_q;
    assign rdata_o   = !buf_empty ? buf_head.data : (rd_inflight_q ? sram_rdata_i : '0);
    assign rlast_o   = !buf_empty ? buf_head.last : (rd_inflight_q && rd_last_q);
    assign out_pop   = rvalid_o && rready_i;
    assign buf_pop   = out_pop && !buf_empty;
    assign buf_push  = rd_inflight_q && !(buf_empty && rready_i);

    sram_rdata_buf u_rdata_buf (
        .clk        (aclk_i),
        .rst_n      (aresetn_i),
        .push       (buf_push),
        .push_entry ({rd_last_q, sram_rdata_i}),
        .pop        (buf_pop),
        .head       (buf_head),
        .count      (buf_count)
    );

endmodule

// File: tb/tb_sram_rw_arb.sv
// Scoreboard bench for sram_rw_arb: SRAM model, reference memory, queued expectations.
// Directed timing scenarios followed by randomized bursts with random backpressure.
module tb_sram_rw_arb;
    import sram_arb_pkg::*;

    localparam int AW = AXI4_ADDR_WIDTH;
    localparam int DW = AXI4_DATA_WIDTH;
    localparam int SW = DW / 8;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [SW-1:0] s;
    } wr_t;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          wbeat_valid = 1'b0, wbeat_ready, wbeat_last = 1'b0;
    logic [AW-1:0] wbeat_addr = '0;
    logic [DW-1:0] wbeat_data = '0;
    logic [SW-1:0] wbeat_strb = '0;
    logic          bvalid, bready;
    logic          rbeat_valid = 1'b0, rbeat_ready, rbeat_last = 1'b0;
    logic [AW-1:0] rbeat_addr = '0;
    logic [DW-1:0] rdata;
    logic          rlast, rvalid, rready;
    logic          sram_en, sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [SW-1:0] sram_wstrb;
    logic [DW-1:0] sram_rdata = '0;

    logic rready_fixed = 1'b1, bready_fixed = 1'b1, rnd_en = 1'b0;
    logic rr_rand = 1'b1, br_rand = 1'b1;
    assign rready = rnd_en ? rr_rand : rready_fixed;
    assign bready = rnd_en ? br_rand : bready_fixed;

    logic [DW-1:0] sram_mem [64];
    logic [DW-1:0] ref_mem  [64];

    wr_t           exp_wr[$];
    logic [AW-1:0] exp_raddr[$];
    logic [DW:0]   exp_rdata[$];
    int            exp_b = 0;
    int            wr_cyc[$], rd_cyc[$], rv_cyc[$], b_cyc[$];
    bit            grant_log[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit abort_rd = 1'b0;
    bit rd_done = 1'b0;

    sram_rw_arb dut (
        .aclk_i        (aclk),
        .aresetn_i     (aresetn),
        .wbeat_valid_i (wbeat_valid),
        .wbeat_ready_o (wbeat_ready),
        .wbeat_addr_i  (wbeat_addr),
        .wbeat_data_i  (wbeat_data),
        .wbeat_strb_i  (wbeat_strb),
        .wbeat_last_i  (wbeat_last),
        .bvalid_o      (bvalid),
        .bready_i      (bready),
        .rbeat_valid_i (rbeat_valid),
        .rbeat_ready_o (rbeat_ready),
        .rbeat_addr_i  (rbeat_addr),
        .rbeat_last_i  (rbeat_last),
        .rdata_o       (rdata),
        .rlast_o       (rlast),
        .rvalid_o      (rvalid),
        .rready_i      (rready),
        .sram_en_o     (sram_en),
        .sram_we_o     (sram_we),
        .sram_addr_o   (sram_addr),
        .sram_wdata_o  (sram_wdata),
        .sram_wstrb_o  (sram_wstrb),
        .sram_rdata_i  (sram_rdata)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    // SRAM macro model: one-cycle read latency, garbage on the output otherwise.
    always @(posedge aclk) begin
        if (sram_en && sram_we) begin
            for (int b = 0; b < SW; b++) begin
                if (sram_wstrb[b]) sram_mem[sram_addr[7:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
            end
        end
        if (sram_en && !sram_we) sram_rdata <= sram_mem[sram_addr[7:2]];
        else                     sram_rdata <= $urandom;
    end

    initial forever begin
        @(posedge aclk);
        #1;
        rr_rand = ($urandom_range(0, 3) != 0);
        br_rand = 1'($urandom_range(0, 1));
    end

    function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic void unexpected(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: DUT event with no expectation queued (cycle %0d)", nm, cyc);
    endfunction

    // Monitor: compares every DUT-presented transaction against the queues.
    initial forever begin
        @(negedge aclk);
        if (aresetn) begin
            if (sram_en && sram_we) begin
                wr_cyc.push_back(cyc);
                grant_log.push_back(1'b0);
                if (exp_wr.size() == 0) unexpected("sram_write");
                else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    check("sram_waddr", 64'(sram_addr), 64'(e.a));
                    check("sram_wdata", 64'(sram_wdata), 64'(e.d));
                    check("sram_wstrb", 64'(sram_wstrb), 64'(e.s));
                end
            end else if (sram_en) begin
                rd_cyc.push_back(cyc);
                grant_log.push_back(1'b1);
                check("sram_rd_wstrb", 64'(sram_wstrb), 64'd0);
                if (exp_raddr.size() == 0) unexpected("sram_read");
                else check("sram_raddr", 64'(sram_addr), 64'(exp_raddr.pop_front()));
            end
            if (rvalid && rready) begin
                rv_cyc.push_back(cyc);
                if (exp_rdata.size() == 0) unexpected("rdata");
                else check("rdata_rlast", 64'({rlast, rdata}), 64'(exp_rdata.pop_front()));
            end
            if (bvalid && bready) begin
                b_cyc.push_back(cyc);
                if (exp_b == 0) unexpected("bresp");
                else exp_b--;
            end
        end
    end

    task automatic wait_hs(input bit is_wr, input string nm);
        int t = 0;
        bit hs = 1'b0;
        while (!hs) begin
            @(negedge aclk);
            hs = is_wr ? (wbeat_valid && wbeat_ready) : (rbeat_valid && rbeat_ready);
            @(posedge aclk);
            #1;
            if (!is_wr && abort_rd) return;
            t++;
            if (!hs && t > 400) begin
                checks++;
                errors++;
                $display("FAIL %s: no handshake within 400 cycles", nm);
                return;
            end
        end
    endtask

    task automatic wr_burst(input logic [AW-1:0] base, input int n, input bit full);
        for (int i = 0; i < n; i++) begin
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            logic [SW-1:0] s;
            a = base + AW'(4 * i);
            d = $urandom;
            s = full ? '1 : SW'($urandom_range(0, 15));
            wbeat_valid = 1'b1;
            wbeat_addr  = a;
            wbeat_data  = d;
            wbeat_strb  = s;
            wbeat_last  = (i == n - 1);
            exp_wr.push_back(wr_t'{a, d, s});
            for (int b = 0; b < SW; b++) begin
                if (s[b]) ref_mem[a[7:2]][8*b +: 8] = d[8*b +: 8];
            end
            if (i == n - 1) exp_b++;
            wait_hs(1'b1, "wr_beat_hs");
        end
        wbeat_valid = 1'b0;
        wbeat_last  = 1'b0;
    endtask

    task automatic rd_burst(input logic [AW-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            logic [AW-1:0] a;
            a = base + AW'(4 * i);
            rbeat_valid = 1'b1;
            rbeat_addr  = a;
            rbeat_last  = (i == n - 1);
            exp_raddr.push_back(a);
            exp_rdata.push_back({rbeat_last, ref_mem[a[7:2]]});
            wait_hs(1'b0, "rd_beat_hs");
            if (abort_rd) break;
        end
        rbeat_valid = 1'b0;
        rbeat_last  = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        int t = 0;
        while ((exp_wr.size() != 0 || exp_raddr.size() != 0 || exp_rdata.size() != 0 || exp_b != 0)
               && t < 1000) begin
            @(posedge aclk);
            #1;
            t++;
        end
        if (t >= 1000) begin
            checks++;
            errors++;
            $display("FAIL %s: not drained, wr=%0d raddr=%0d rdata=%0d b=%0d", nm,
                     exp_wr.size(), exp_raddr.size(), exp_rdata.size(), exp_b);
        end
        repeat (2) @(posedge aclk);
        #1;
    endtask

    task automatic clear_logs();
        wr_cyc.delete();
        rd_cyc.delete();
        rv_cyc.delete();
        b_cyc.delete();
        grant_log.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  t0;
        bit  exp_gnt [3];

        repeat (3) @(posedge aclk);
        #1;
        check("rst_rvalid", 64'(rvalid), 64'd0);
        check("rst_rlast", 64'(rlast), 64'd0);
        check("rst_rdata", 64'(rdata), 64'd0);
        check("rst_bvalid", 64'(bvalid), 64'd0);
        check("rst_wbeat_ready", 64'(wbeat_ready), 64'd0);
        check("rst_rbeat_ready", 64'(rbeat_ready), 64'd0);
        check("rst_sram_en", 64'(sram_en), 64'd0);
        check("rst_sram_we", 64'(sram_we), 64'd0);
        check("rst_state", 64'(dut.state_q), 64'(IDLE));
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        for (int k = 0; k < 4; k++) wr_burst(AW'(k * 64), 16, 1'b1);
        wait_drain("prefill");

        // 4-beat write: grant next cycle, back-to-back beats, response one cycle later.
        clear_logs();
        t0 = cyc;
        wr_burst(AW'('h100), 4, 1'b1);
        wait_drain("wr4");
        check("wr4_beats", 64'(wr_cyc.size()), 64'd4);
        check("wr4_bresp_count", 64'(b_cyc.size()), 64'd1);
        if (wr_cyc.size() == 4 && b_cyc.size() == 1) begin
            check("wr4_first_cycle", 64'(wr_cyc[0]), 64'(t0 + 1));
            check("wr4_last_cycle", 64'(wr_cyc[3]), 64'(t0 + 4));
            check("wr4_bvalid_cycle", 64'(b_cyc[0]), 64'(t0 + 5));
        end
        check("wr4_state_idle", 64'(dut.state_q), 64'(IDLE));

        // 4-beat read, rready high: data on the four cycles after each address.
        clear_logs();
        t0 = cyc;
        rd_burst(AW'('h100), 4);
        wait_drain("rd4");
        check("rd4_addr_count", 64'(rd_cyc.size()), 64'd4);
        check("rd4_data_count", 64'(rv_cyc.size()), 64'd4);
        if (rd_cyc.size() == 4 && rv_cyc.size() == 4) begin
            check("rd4_first_addr_cycle", 64'(rd_cyc[0]), 64'(t0 + 1));
            check("rd4_last_addr_cycle", 64'(rd_cyc[3]), 64'(t0 + 4));
            check("rd4_first_data_cycle", 64'(rv_cyc[0]), 64'(t0 + 2));
            check("rd4_last_data_cycle", 64'(rv_cyc[3]), 64'(t0 + 5));
        end

        // Read credit: with rready low only two reads may be outstanding.
        clear_logs();
        rready_fixed = 1'b0;
        rd_done = 1'b0;
        fork
            begin
                rd_burst(AW'('h40), 4);
                rd_done = 1'b1;
            end
        join_none
        repeat (8) @(posedge aclk);
        #1;
        check("credit_reads_issued", 64'(rd_cyc.size()), 64'd2);
        check("credit_rbeat_ready", 64'(rbeat_ready), 64'd0);
        check("credit_rvalid_held", 64'(rvalid), 64'd1);
        rready_fixed = 1'b1;
        wait_drain("credit");
        check("credit_done", 64'(rd_done), 64'd1);
        check("credit_reads_total", 64'(rd_cyc.size()), 64'd4);

        // Both sides requesting continuously: first three grants.
        clear_logs();
        fork
            for (int k = 0; k < 3; k++) rd_burst(AW'(k * 4), 1);
            for (int k = 0; k < 3; k++) wr_burst(AW'(128 + k * 4), 1, 1'b1);
        join
        wait_drain("tie");
`ifdef SRAM_ARB_RR_EN
        exp_gnt = '{1'b1, 1'b0, 1'b1};
`else
        exp_gnt = '{1'b1, 1'b1, 1'b1};
`endif
        check("tie_grant_count", 64'(grant_log.size()), 64'd6);
        if (grant_log.size() >= 3) begin
            for (int k = 0; k < 3; k++) check($sformatf("tie_grant%0d_is_rd", k),
                                              64'(grant_log[k]), 64'(exp_gnt[k]));
        end

        // Reset mid read burst with two words buffered.
        clear_logs();
        rready_fixed = 1'b0;
        abort_rd = 1'b0;
        fork
            rd_burst(AW'('h80), 4);
        join_none
        repeat (6) @(posedge aclk);
        #1;
        check("rstmid_rvalid_before", 64'(rvalid), 64'd1);
        #2;
        aresetn = 1'b0;
        abort_rd = 1'b1;
        #1;
        check("rstmid_rvalid", 64'(rvalid), 64'd0);
        check("rstmid_state", 64'(dut.state_q), 64'(IDLE));
        check("rstmid_rbeat_ready", 64'(rbeat_ready), 64'd0);
        exp_raddr.delete();
        exp_rdata.delete();
        repeat (3) @(posedge aclk);
        #1;
        rbeat_valid = 1'b0;
        rready_fixed = 1'b1;
        abort_rd = 1'b0;
        aresetn = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        check("rstmid_rvalid_after", 64'(rvalid), 64'd0);

        // Reset while a write response is pending drops it.
        bready_fixed = 1'b0;
        wr_burst(AW'('h20), 2, 1'b1);
        check("bdrop_bvalid_before", 64'(bvalid), 64'd1);
        #2;
        aresetn = 1'b0;
        #1;
        check("bdrop_bvalid", 64'(bvalid), 64'd0);
        exp_b = 0;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        bready_fixed = 1'b1;

        // Fresh write burst after reset, then read it back.
        clear_logs();
        wr_burst(AW'('h30), 4, 1'b0);
        rd_burst(AW'('h30), 4);
        wait_drain("post_reset");
        check("post_reset_writes", 64'(wr_cyc.size()), 64'd4);
        check("post_reset_bresp", 64'(b_cyc.size()), 64'd1);

        // Randomized bursts with random rready/bready backpressure.
        rnd_en = 1'b1;
        for (int k = 0; k < 24; k++) begin
            logic [AW-1:0] base;
            int            len;
            base = AW'($urandom_range(0, 63) * 4);
            len  = int'($urandom_range(1, 8));
            if ($urandom_range(0, 1) == 1) wr_burst(base, len, 1'($urandom_range(0, 1)));
            else                           rd_burst(base, len);
            repeat ($urandom_range(0, 2)) @(posedge aclk);
            #1;
        end
        wait_drain("random");
        rnd_en = 1'b0;

        check("end_exp_wr_empty", 64'(exp_wr.size()), 64'd0);
        check("end_exp_rdata_empty", 64'(exp_rdata.size()), 64'd0);
        check("end_exp_b_zero", 64'(exp_b), 64'd0);
        check("end_state_idle", 64'(dut.state_q), 64'(IDLE));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
